// File: rtl/qtree_level_nary.sv
// One level of an N-ary search-tree lookup pipeline.
// A lookup reads its node (FANOUT-1 keys) from a local RAM, picks the lowest
// child whose key is >= the lookup value and emits {node address, child index}
// plus an exact-match flag through a credit-protected show-ahead FIFO.
module qtree_level_nary #(
    parameter int FANOUT         = 4,
    parameter int KEY_WIDTH      = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int BYPASS_WIDTH   = 1,
    parameter int RAM_LATENCY    = 1,
    parameter int FIFO_DEPTH     = 8,
    parameter int RAM_DATA_WIDTH = KEY_WIDTH * (FANOUT - 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [RAM_DATA_WIDTH-1:0]             mm_ram_data_i,
    input  logic [ADDR_WIDTH-1:0]                 mm_ram_addr_i,
    input  logic                                  mm_ram_write_i,
    input  logic [KEY_WIDTH-1:0]                  in_lookup_value_i,
    input  logic [ADDR_WIDTH-1:0]                 in_addr_i,
    input  logic [BYPASS_WIDTH-1:0]               in_bypass_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    output logic [KEY_WIDTH-1:0]                  out_lookup_value_o,
    output logic [ADDR_WIDTH+$clog2(FANOUT)-1:0]  out_addr_o,
    output logic                                  out_match_o,
    output logic [BYPASS_WIDTH-1:0]               out_bypass_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i
);

    localparam int IDX_W   = $clog2(FANOUT);
    localparam int OUT_AW  = ADDR_WIDTH + IDX_W;
    // Sideband travels alongside the RAM read register plus RAM_LATENCY delay registers.
    localparam int NSTG    = RAM_LATENCY + 1;
    localparam int ENTRY_W = KEY_WIDTH + OUT_AW + 1 + BYPASS_WIDTH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    logic                      accept;
    logic                      pop;
    logic                      ready_reg;
    logic [CNT_W-1:0]          credit_reg;
    logic [CNT_W-1:0]          credit_next;

    logic [RAM_DATA_WIDTH-1:0] ram_mem [2**ADDR_WIDTH];
    logic [RAM_DATA_WIDTH-1:0] ram_rd_reg;
    logic [RAM_DATA_WIDTH-1:0] dly_data_reg [RAM_LATENCY];

    logic [NSTG-1:0]           stg_valid_reg;
    logic [KEY_WIDTH-1:0]      stg_value_reg  [NSTG];
    logic [ADDR_WIDTH-1:0]     stg_addr_reg   [NSTG];
    logic [BYPASS_WIDTH-1:0]   stg_bypass_reg [NSTG];

    logic [RAM_DATA_WIDTH-1:0] node_keys;
    logic [KEY_WIDTH-1:0]      node_value;
    logic [FANOUT-2:0]         key_le;
    logic [FANOUT-2:0]         key_eq;
    logic [IDX_W-1:0]          cmp_idx;
    logic                      cmp_match;
    logic                      cmp_valid_reg;
    logic [ENTRY_W-1:0]        cmp_entry_reg;

    logic [ENTRY_W-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_reg;
    logic [PTR_W-1:0]          rd_ptr_reg;
    logic [CNT_W-1:0]          count_reg;
    logic [ENTRY_W-1:0]        head_entry;

    assign accept     = in_valid_i & ready_reg;
    assign pop        = out_valid_o & out_ready_i;
    assign in_ready_o = ready_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Node RAM: write port for management, read-first registered read port for lookups.
    always_ff @(posedge clk_i) begin
        if (mm_ram_write_i) begin
            ram_mem[mm_ram_addr_i] <= mm_ram_data_i;
        end
        ram_rd_reg <= ram_mem[in_addr_i];
    end

    // RAM output delay line and sideband shift register; only the valids are reset.
    always_ff @(posedge clk_i) begin
        dly_data_reg[0]   <= ram_rd_reg;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            dly_data_reg[i] <= dly_data_reg[i-1];
        end
        stg_value_reg[0]  <= in_lookup_value_i;
        stg_addr_reg[0]   <= in_addr_i;
        stg_bypass_reg[0] <= in_bypass_i;
        for (int i = 1; i < NSTG; i++) begin
            stg_value_reg[i]  <= stg_value_reg[i-1];
            stg_addr_reg[i]   <= stg_addr_reg[i-1];
            stg_bypass_reg[i] <= stg_bypass_reg[i-1];
        end
        if (rst_i) begin
            stg_valid_reg <= '0;
        end else begin
            stg_valid_reg <= {stg_valid_reg[NSTG-2:0], accept};
        end
    end

    assign node_keys  = dly_data_reg[RAM_LATENCY-1];
    assign node_value = stg_value_reg[NSTG-1];

    // One unsigned comparator pair per key.
    generate
        for (genvar gi = 0; gi < FANOUT - 1; gi++) begin : g_key_cmp
            assign key_le[gi] = node_value <= node_keys[gi*KEY_WIDTH +: KEY_WIDTH];
            assign key_eq[gi] = node_value == node_keys[gi*KEY_WIDTH +: KEY_WIDTH];
        end
    endgenerate

    // Priority select: the lowest key that is >= the lookup wins, last child otherwise.
    always_comb begin
        cmp_idx   = IDX_W'(FANOUT - 1);
        cmp_match = 1'b0;
        for (int i = FANOUT - 2; i >= 0; i--) begin
            if (key_le[i]) begin
                cmp_idx   = IDX_W'(i);
                cmp_match = key_eq[i];
            end
        end
    end

    // Compare result register feeding the FIFO write.
    always_ff @(posedge clk_i) begin
        cmp_entry_reg <= {node_value, stg_addr_reg[NSTG-1], cmp_idx, cmp_match,
                          stg_bypass_reg[NSTG-1]};
        if (rst_i) begin
            cmp_valid_reg <= 1'b0;
        end else begin
            cmp_valid_reg <= stg_valid_reg[NSTG-1];
        end
    end

    // FIFO storage; space is guaranteed by the credit counter so writes never check full.
    always_ff @(posedge clk_i) begin
        if (cmp_valid_reg) begin
            fifo_mem[wr_ptr_reg] <= cmp_entry_reg;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (cmp_valid_reg) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)           rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_reg + CNT_W'(cmp_valid_reg) - CNT_W'(pop);
        end
    end

    // Credits cover both in-flight lookups and FIFO occupancy.
    always_comb begin
        credit_next = credit_reg + CNT_W'(accept) - CNT_W'(pop);
    end

    // Registered ready keeps out_ready_i off any combinational path to in_ready_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_reg <= '0;
            ready_reg  <= 1'b0;
        end else begin
            credit_reg <= credit_next;
            ready_reg  <= credit_next < CNT_W'(FIFO_DEPTH);
        end
    end

    // Show-ahead head; data outputs read as zero while the FIFO is empty.
    assign out_valid_o = (count_reg != '0);
    assign head_entry  = out_valid_o ? fifo_mem[rd_ptr_reg] : '0;
    assign {out_lookup_value_o, out_addr_o, out_match_o, out_bypass_o} = head_entry;

endmodule

// File: tb/tb_qtree_level_nary.sv
// Directed and random bench for qtree_level_nary: instance A (FANOUT=4,
// RAM_LATENCY=1, FIFO_DEPTH=8) and instance B (FANOUT=8, RAM_LATENCY=2,
// FIFO_DEPTH=5), each with a reference-model scoreboard.
module tb_qtree_level_nary;

    typedef struct {
        logic [15:0] val;
        logic [7:0]  addr;
        logic        m;
        logic [7:0]  byp;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic       m;
        logic [7:0] byp;
        int         cyc;
    } log_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A signals
    logic [47:0]  a_mm_data;
    logic [3:0]   a_mm_addr;
    logic         a_mm_we;
    logic [15:0]  a_val;
    logic [3:0]   a_addr;
    logic [7:0]   a_byp;
    logic         a_iv, a_ir;
    logic [15:0]  a_oval;
    logic [5:0]   a_oaddr;
    logic         a_om;
    logic [7:0]   a_obyp;
    logic         a_ov, a_ordy;

    // Instance B signals
    logic [111:0] b_mm_data;
    logic [3:0]   b_mm_addr;
    logic         b_mm_we;
    logic [15:0]  b_val;
    logic [3:0]   b_addr;
    logic [7:0]   b_byp;
    logic         b_iv, b_ir;
    logic [15:0]  b_oval;
    logic [6:0]   b_oaddr;
    logic         b_om;
    logic [7:0]   b_obyp;
    logic         b_ov, b_ordy;

    qtree_level_nary #(
        .FANOUT(4), .KEY_WIDTH(16), .ADDR_WIDTH(4), .BYPASS_WIDTH(8),
        .RAM_LATENCY(1), .FIFO_DEPTH(8)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .mm_ram_data_i(a_mm_data), .mm_ram_addr_i(a_mm_addr), .mm_ram_write_i(a_mm_we),
        .in_lookup_value_i(a_val), .in_addr_i(a_addr), .in_bypass_i(a_byp),
        .in_valid_i(a_iv), .in_ready_o(a_ir),
        .out_lookup_value_o(a_oval), .out_addr_o(a_oaddr), .out_match_o(a_om),
        .out_bypass_o(a_obyp), .out_valid_o(a_ov), .out_ready_i(a_ordy)
    );

    qtree_level_nary #(
        .FANOUT(8), .KEY_WIDTH(16), .ADDR_WIDTH(4), .BYPASS_WIDTH(8),
        .RAM_LATENCY(2), .FIFO_DEPTH(5)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .mm_ram_data_i(b_mm_data), .mm_ram_addr_i(b_mm_addr), .mm_ram_write_i(b_mm_we),
        .in_lookup_value_i(b_val), .in_addr_i(b_addr), .in_bypass_i(b_byp),
        .in_valid_i(b_iv), .in_ready_o(b_ir),
        .out_lookup_value_o(b_oval), .out_addr_o(b_oaddr), .out_match_o(b_om),
        .out_bypass_o(b_obyp), .out_valid_o(b_ov), .out_ready_i(b_ordy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    log_t log_a[$];
    log_t log_b[$];
    int unsigned mir_a [16][7];
    int unsigned mir_b [16][7];
    int acc_a = 0;
    int acc_b = 0;
    bit lat_arm = 0;
    int lat_acc = -1;
    int lat_out = -1;
    bit rand_en = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, got, exp);
        end
    endtask

    // Reference: lowest index whose key is >= v, nk when none; match only on a real key.
    function automatic void model(input int unsigned v, input int unsigned k[7], input int nk,
                                  output int idx, output bit m);
        idx = nk;
        for (int i = 0; i < nk; i++) begin
            if (idx == nk && v <= k[i]) idx = i;
        end
        m = 1'b0;
        if (idx < nk) m = (v == k[idx]);
    endfunction

    task automatic check_out(input string inst, input exp_t e, input logic [15:0] v,
                             input logic [7:0] ad, input logic m, input logic [7:0] b);
        chk({inst, "_out_value"},  32'(v),  32'(e.val));
        chk({inst, "_out_addr"},   32'(ad), 32'(e.addr));
        chk({inst, "_out_match"},  32'(m),  32'(e.m));
        chk({inst, "_out_bypass"}, 32'(b),  32'(e.byp));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor A: pops and checks outputs, pushes expectations on accept, mirrors RAM writes.
    initial begin : mon_a
        exp_t e;
        log_t l;
        int idx;
        bit m;
        int unsigned k[7];
        bit stall;
        logic [31:0] held;
        stall = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q_a.delete();
                stall = 0;
            end else begin
                if (stall && a_ov) chk("A_stable", held, {1'b0, a_oval, a_oaddr, a_om, a_obyp});
                if (a_ov && a_ordy) begin
                    checks++;
                    assert (q_a.size() != 0) else begin
                        errors++;
                        $error("FAIL A_unexpected_output: observed addr=%0d byp=%0d, required none", a_oaddr, a_obyp);
                    end
                    if (q_a.size() != 0) begin
                        e = q_a.pop_front();
                        check_out("A", e, a_oval, 8'(a_oaddr), a_om, a_obyp);
                    end
                    l.addr = 8'(a_oaddr); l.m = a_om; l.byp = a_obyp; l.cyc = cyc;
                    log_a.push_back(l);
                    $display("[A] cyc=%0d val=%0d addr=%0d match=%0d byp=%0d", cyc, a_oval, a_oaddr, a_om, a_obyp);
                end
                stall = a_ov && !a_ordy;
                held = {1'b0, a_oval, a_oaddr, a_om, a_obyp};
                if (a_iv && a_ir) begin
                    for (int i = 0; i < 7; i++) k[i] = mir_a[a_addr][i];
                    model(a_val, k, 3, idx, m);
                    e.val = a_val; e.addr = 8'(int'(a_addr) * 4 + idx); e.m = m; e.byp = a_byp;
                    q_a.push_back(e);
                    acc_a++;
                    if (lat_arm && lat_acc < 0) lat_acc = cyc + 1;
                end
                if (lat_arm && a_ov && lat_out < 0) lat_out = cyc;
            end
            if (a_mm_we) begin
                for (int i = 0; i < 3; i++) mir_a[a_mm_addr][i] = a_mm_data[i*16 +: 16];
            end
        end
    end

    // Monitor B: same scheme for the FANOUT=8 instance.
    initial begin : mon_b
        exp_t e;
        log_t l;
        int idx;
        bit m;
        int unsigned k[7];
        bit stall;
        logic [31:0] held;
        stall = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q_b.delete();
                stall = 0;
            end else begin
                if (stall && b_ov) chk("B_stable", held, {b_oval, b_oaddr, b_om, b_obyp});
                if (b_ov && b_ordy) begin
                    checks++;
                    assert (q_b.size() != 0) else begin
                        errors++;
                        $error("FAIL B_unexpected_output: observed addr=%0d byp=%0d, required none", b_oaddr, b_obyp);
                    end
                    if (q_b.size() != 0) begin
                        e = q_b.pop_front();
                        check_out("B", e, b_oval, 8'(b_oaddr), b_om, b_obyp);
                    end
                    l.addr = 8'(b_oaddr); l.m = b_om; l.byp = b_obyp; l.cyc = cyc;
                    log_b.push_back(l);
                    $display("[B] cyc=%0d val=%0d addr=%0d match=%0d byp=%0d", cyc, b_oval, b_oaddr, b_om, b_obyp);
                end
                stall = b_ov && !b_ordy;
                held = {b_oval, b_oaddr, b_om, b_obyp};
                if (b_iv && b_ir) begin
                    for (int i = 0; i < 7; i++) k[i] = mir_b[b_addr][i];
                    model(b_val, k, 7, idx, m);
                    e.val = b_val; e.addr = 8'(int'(b_addr) * 8 + idx); e.m = m; e.byp = b_byp;
                    q_b.push_back(e);
                    acc_b++;
                end
            end
            if (b_mm_we) begin
                for (int i = 0; i < 7; i++) mir_b[b_mm_addr][i] = b_mm_data[i*16 +: 16];
            end
        end
    end

    // Random downstream backpressure for instance B.
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_en) b_ordy = 1'($urandom % 2);
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input int v, input int ad, input int b);
        int n;
        a_val = 16'(v); a_addr = 4'(ad); a_byp = 8'(b); a_iv = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_ir && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("A_ready_timeout", 32'(a_ir), 1);
        tick();
    endtask

    task automatic send_b(input int v, input int ad, input int b);
        int n;
        b_val = 16'(v); b_addr = 4'(ad); b_byp = 8'(b); b_iv = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_ir && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("B_ready_timeout", 32'(b_ir), 1);
        tick();
    endtask

    task automatic drain_a();
        int n = 0;
        while (q_a.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk("A_drain", 32'(q_a.size()), 0);
    endtask

    task automatic drain_b();
        int n = 0;
        while (q_b.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        chk("B_drain", 32'(q_b.size()), 0);
    endtask

    initial begin : stim
        int s;
        int acc0;
        rst = 1'b1;
        a_mm_data = '0; a_mm_addr = '0; a_mm_we = 1'b0;
        a_val = '0; a_addr = '0; a_byp = '0; a_iv = 1'b0; a_ordy = 1'b0;
        b_mm_data = '0; b_mm_addr = '0; b_mm_we = 1'b0;
        b_val = '0; b_addr = '0; b_byp = '0; b_iv = 1'b0; b_ordy = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("A_rst_in_ready", 32'(a_ir), 0);
        chk("A_rst_out_valid", 32'(a_ov), 0);
        chk("A_rst_out_addr", 32'(a_oaddr), 0);
        chk("A_rst_out_value", 32'(a_oval), 0);
        chk("A_rst_out_match", 32'(a_om), 0);
        chk("A_rst_out_bypass", 32'(a_obyp), 0);
        chk("B_rst_in_ready", 32'(b_ir), 0);
        chk("B_rst_out_valid", 32'(b_ov), 0);
        rst = 1'b0;
        tick();
        chk("A_ready_after_rst", 32'(a_ir), 1);
        chk("B_ready_after_rst", 32'(b_ir), 1);

        // Node 5 = {10,20,30}; four back-to-back lookups with latency and throughput
        a_mm_addr = 4'd5; a_mm_data = {16'd30, 16'd20, 16'd10}; a_mm_we = 1'b1;
        tick();
        a_mm_we = 1'b0;
        a_ordy = 1'b1;
        s = log_a.size();
        lat_acc = -1; lat_out = -1; lat_arm = 1'b1;
        send_a(0, 5, 0);
        send_a(15, 5, 1);
        send_a(20, 5, 2);
        send_a(31, 5, 3);
        a_iv = 1'b0;
        drain_a();
        repeat (2) tick();
        lat_arm = 1'b0;
        chk("T1_latency", 32'(lat_out - lat_acc), 3);
        chk("T1_count", 32'(log_a.size() - s), 4);
        if (log_a.size() >= s + 4) begin
            chk("T1_addr0", 32'(log_a[s].addr), 20);   chk("T1_match0", 32'(log_a[s].m), 0);
            chk("T1_addr1", 32'(log_a[s+1].addr), 21); chk("T1_match1", 32'(log_a[s+1].m), 0);
            chk("T1_addr2", 32'(log_a[s+2].addr), 21); chk("T1_match2", 32'(log_a[s+2].m), 1);
            chk("T1_addr3", 32'(log_a[s+3].addr), 23); chk("T1_match3", 32'(log_a[s+3].m), 0);
            chk("T1_throughput", 32'(log_a[s+3].cyc - log_a[s].cyc), 3);
        end

        // Stalled downstream: exactly FIFO_DEPTH accepted, then drain in order
        a_ordy = 1'b0;
        s = log_a.size();
        acc0 = acc_a;
        for (int t = 0; t < 8; t++) send_a(t * 3, 5, t);
        a_val = 16'd24; a_addr = 4'd5; a_byp = 8'd8; a_iv = 1'b1;
        repeat (12) @(negedge clk);
        chk("T2_accepted", 32'(acc_a - acc0), 8);
        chk("T2_in_ready_low", 32'(a_ir), 0);
        chk("T2_out_valid", 32'(a_ov), 1);
        chk("T2_no_pops", 32'(log_a.size() - s), 0);
        tick();
        a_ordy = 1'b1;
        for (int t = 8; t < 20; t++) send_a(t * 3, 5, t);
        a_iv = 1'b0;
        drain_a();
        chk("T2_total", 32'(acc_a - acc0), 20);
        chk("T2_pops", 32'(log_a.size() - s), 20);
        if (log_a.size() >= s + 20) begin
            for (int t = 0; t < 20; t++) chk("T2_bypass_order", 32'(log_a[s+t].byp), 32'(t));
        end

        // Read-first collision on node 3
        a_mm_addr = 4'd3; a_mm_data = {16'd3, 16'd2, 16'd1}; a_mm_we = 1'b1;
        tick();
        a_mm_data = {16'd300, 16'd200, 16'd100};
        s = log_a.size();
        send_a(50, 3, 8'h40);
        a_mm_we = 1'b0;
        send_a(50, 3, 8'h41);
        a_iv = 1'b0;
        drain_a();
        chk("T4_count", 32'(log_a.size() - s), 2);
        if (log_a.size() >= s + 2) begin
            chk("T4_old_addr", 32'(log_a[s].addr), 15);
            chk("T4_new_addr", 32'(log_a[s+1].addr), 12);
            chk("T4_new_match", 32'(log_a[s+1].m), 0);
        end

        // Reset with lookups in flight and buffered
        a_ordy = 1'b0;
        for (int t = 0; t < 6; t++) send_a(t * 7, 5, 8'h80 + t);
        a_val = 16'd25; a_byp = 8'h99;
        rst = 1'b1;
        tick();
        chk("T5_out_valid_after_rst", 32'(a_ov), 0);
        chk("T5_in_ready_during_rst", 32'(a_ir), 0);
        chk("T5_out_addr_after_rst", 32'(a_oaddr), 0);
        rst = 1'b0;
        a_iv = 1'b0;
        a_ordy = 1'b1;
        tick();
        chk("T5_ready_after_rst", 32'(a_ir), 1);
        repeat (10) tick();
        chk("T5_no_stale", 32'(a_ov), 0);
        s = log_a.size();
        send_a(25, 5, 8'h50);
        a_iv = 1'b0;
        drain_a();
        chk("T5_post_count", 32'(log_a.size() - s), 1);
        if (log_a.size() >= s + 1) chk("T5_ram_intact_addr", 32'(log_a[s].addr), 22);

        // FANOUT=8 boundary: node 0 = {5,10,...,35}
        b_mm_addr = 4'd0;
        for (int i = 0; i < 7; i++) b_mm_data[i*16 +: 16] = 16'(5 * (i + 1));
        b_mm_we = 1'b1;
        tick();
        b_mm_we = 1'b0;
        b_ordy = 1'b1;
        s = log_b.size();
        send_b(36, 0, 1);
        send_b(35, 0, 2);
        b_iv = 1'b0;
        drain_b();
        chk("T6_count", 32'(log_b.size() - s), 2);
        if (log_b.size() >= s + 2) begin
            chk("T6_addr36", 32'(log_b[s].addr), 7);
            chk("T6_match36", 32'(log_b[s].m), 0);
            chk("T6_addr35", 32'(log_b[s+1].addr), 6);
            chk("T6_match35", 32'(log_b[s+1].m), 1);
        end

        // Random lookups against random nodes with 50% backpressure
        for (int n = 0; n < 16; n++) begin
            b_mm_addr = 4'(n);
            for (int i = 0; i < 7; i++) begin
                if (n % 2 == 0) b_mm_data[i*16 +: 16] = 16'(i * 9 + $urandom_range(0, 8));
                else            b_mm_data[i*16 +: 16] = 16'($urandom_range(0, 63));
            end
            b_mm_we = 1'b1;
            tick();
        end
        b_mm_we = 1'b0;
        s = log_b.size();
        rand_en = 1'b1;
        for (int i = 0; i < 1000; i++) send_b($urandom_range(0, 70), $urandom_range(0, 15), i % 256);
        b_iv = 1'b0;
        rand_en = 1'b0;
        tick();
        b_ordy = 1'b1;
        drain_b();
        chk("T3_pops", 32'(log_b.size() - s), 1000);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
